// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared types and constants for the SPI slave responder
package spi_slave_pkg;

  // Response source selected at the start of each frame; 3 behaves as fill
  typedef enum logic [1:0] {
    MODE_FIFO = 2'd0,
    MODE_ECHO = 2'd1,
    MODE_FILL = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam int STAT_RX_OVERRUN  = 0;
  localparam int STAT_TX_UNDERRUN = 1;
  localparam int STAT_PARTIAL     = 2;

endpackage

// File: rtl/spi_slave_fifo.sv
// rtl/spi_slave_fifo.sv - synchronous first-word fall-through FIFO
module spi_slave_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         empty, full, do_push, do_pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a simultaneous push
  assign do_pop  = out_ready && !empty;
  assign do_push = in_valid && (!full || do_pop);

  // Next pointers and memory contents
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer and storage registers; storage needs no reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/spi_slave_model.sv
// rtl/spi_slave_model.sv - oversampled SPI slave responder with RX/TX FIFOs
module spi_slave_model
  import spi_slave_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                RX_DEPTH  = 16,
  parameter int                TX_DEPTH  = 16,
  parameter int                CPOL      = 0,
  parameter int                CPHA      = 0,
  parameter int                LSB_FIRST = 0,
  parameter logic [DATA_W-1:0] FILL      = '1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [1:0]        mode,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic [15:0]       frame_cnt,
  output logic [2:0]        status,
  input  logic              status_clr
);

  localparam int CW = $clog2(DATA_W + 1);

  logic              cs_s1_q, cs_s2_q, sclk_s1_q, sclk_s2_q, sclk_s3_q, mosi_s1_q, mosi_s2_q;
  logic              oe_q, miso_q, miso_d, under_pend_q, under_pend_d;
  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, rx_new, load_word, tx_head;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [2:0]        status_q, status_d;
  logic              sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic              rx_push, rx_in_ready, tx_pop, tx_avail, reload, first_word;

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  assign sclk_rise   = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall   = ~sclk_s2_q & sclk_s3_q;
  assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
  assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
  assign rx_new      = (LSB_FIRST != 0) ? {mosi_s2_q, rx_sr_q[DATA_W-1:1]}
                                        : {rx_sr_q[DATA_W-2:0], mosi_s2_q};

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign frame_cnt   = frame_cnt_q;
  assign status      = status_q;

  spi_slave_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn),
    .in_valid(rx_push), .in_ready(rx_in_ready), .in_data(rx_new),
    .out_valid(rx_valid), .out_ready(rx_ready), .out_data(rx_data)
  );

  spi_slave_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn),
    .in_valid(tx_valid), .in_ready(tx_ready), .in_data(tx_data),
    .out_valid(tx_avail), .out_ready(tx_pop), .out_data(tx_head)
  );

  // Frame FSM, shift datapath, word reload and sticky status
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    bit_cnt_d    = bit_cnt_q;
    rx_sr_d      = rx_sr_q;
    tx_sr_d      = tx_sr_q;
    miso_d       = miso_q;
    frame_cnt_d  = frame_cnt_q;
    status_d     = status_q;
    under_pend_d = under_pend_q;
    rx_push      = 1'b0;
    tx_pop       = 1'b0;
    reload       = 1'b0;
    first_word   = 1'b0;
    load_word    = FILL;
    if (status_clr) status_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (!cs_s2_q) begin
          state_d = ST_LOAD;
          mode_d  = mode;
        end
      end
      ST_LOAD, ST_SHIFT: begin
        if (cs_s2_q) begin
          state_d      = ST_IDLE;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          if (bit_cnt_q != '0) status_d[STAT_PARTIAL] = 1'b1;
          bit_cnt_d    = '0;
          under_pend_d = 1'b0;
        end else if (state_q == ST_LOAD) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = '0;
          reload     = 1'b1;
          first_word = 1'b1;
        end else if (sample_edge) begin
          rx_sr_d = rx_new;
          // An underrun only counts once the master actually clocks the substituted word,
          // so the speculative reload after a frame's last word never flags it
          if (under_pend_q) begin
            status_d[STAT_TX_UNDERRUN] = 1'b1;
            under_pend_d = 1'b0;
          end
          if (bit_cnt_q == CW'(DATA_W - 1)) begin
            rx_push   = 1'b1;
            if (!rx_in_ready && !rx_ready) status_d[STAT_RX_OVERRUN] = 1'b1;
            bit_cnt_d = '0;
            reload    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (shift_edge && (CPHA != 0 || bit_cnt_q != '0)) begin
          // With CPHA=0 the reload already presented bit 0, so the trailing edge
          // that closes a word must not advance
          miso_d  = head_bit(tx_sr_q);
          tx_sr_d = advance(tx_sr_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reload) begin
      under_pend_d = 1'b0;
      case (mode_q)
        MODE_FIFO: begin
          if (tx_avail) begin
            load_word = tx_head;
            tx_pop    = 1'b1;
          end else begin
            under_pend_d = 1'b1;
          end
        end
        MODE_ECHO: load_word = first_word ? FILL : rx_new;
        default:   load_word = FILL;
      endcase
      if (CPHA == 0) begin
        miso_d  = head_bit(load_word);
        tx_sr_d = advance(load_word);
      end else begin
        tx_sr_d = load_word;
      end
    end
  end

  // Synchronisers, output enable and all state registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cs_s1_q      <= 1'b1;
      cs_s2_q      <= 1'b1;
      sclk_s1_q    <= (CPOL != 0);
      sclk_s2_q    <= (CPOL != 0);
      sclk_s3_q    <= (CPOL != 0);
      mosi_s1_q    <= 1'b0;
      mosi_s2_q    <= 1'b0;
      oe_q         <= 1'b0;
      miso_q       <= 1'b0;
      state_q      <= ST_IDLE;
      mode_q       <= MODE_FIFO;
      bit_cnt_q    <= '0;
      rx_sr_q      <= '0;
      tx_sr_q      <= '0;
      frame_cnt_q  <= '0;
      status_q     <= '0;
      under_pend_q <= 1'b0;
    end else begin
      cs_s1_q      <= spi_cs;
      cs_s2_q      <= cs_s1_q;
      sclk_s1_q    <= spi_sclk;
      sclk_s2_q    <= sclk_s1_q;
      sclk_s3_q    <= sclk_s2_q;
      mosi_s1_q    <= spi_mosi;
      mosi_s2_q    <= mosi_s1_q;
      oe_q         <= ~cs_s2_q;
      miso_q       <= miso_d;
      state_q      <= state_d;
      mode_q       <= mode_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_sr_q      <= rx_sr_d;
      tx_sr_q      <= tx_sr_d;
      frame_cnt_q  <= frame_cnt_d;
      status_q     <= status_d;
      under_pend_q <= under_pend_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_model.sv
// tb/tb_spi_slave_model.sv - scoreboard bench for the SPI slave responder
module tb_spi_slave_model;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rstn, status_clr;
  logic [1:0]  mode;
  logic        cs [4], sclk [4], mosi [4], miso [4], oe [4];
  logic        tx_valid [4], tx_ready [4], rx_valid [4], rx_ready [4];
  logic [7:0]  tx_data [4], rx_data [4];
  logic [15:0] frame_cnt [4];
  logic [2:0]  status [4];

  logic [7:0]  mosi_words [8];
  logic [7:0]  miso_words [8];
  logic [7:0]  exp_miso_q [$];
  logic [7:0]  exp_rx_q [$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // Instance k: CPOL=k/2, CPHA=k%2, LSB first except instance 0, RX depth 2 on instance 0
  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_model #(
      .DATA_W(8), .RX_DEPTH((g == 0) ? 2 : 16), .TX_DEPTH(16),
      .CPOL(g / 2), .CPHA(g % 2), .LSB_FIRST((g == 0) ? 0 : 1), .FILL(8'hFF)
    ) u_dut (
      .clk(clk), .rstn(rstn), .spi_cs(cs[g]), .spi_sclk(sclk[g]), .spi_mosi(mosi[g]),
      .spi_miso(miso[g]), .spi_miso_oe(oe[g]), .mode(mode),
      .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]), .tx_data(tx_data[g]),
      .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]), .rx_data(rx_data[g]),
      .frame_cnt(frame_cnt[g]), .status(status[g]), .status_clr(status_clr)
    );
  end

  task automatic half_per();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic push_tx(input int k, input logic [7:0] d);
    @(negedge clk);
    tx_valid[k] = 1'b1;
    tx_data[k]  = d;
    @(negedge clk);
    tx_valid[k] = 1'b0;
  endtask

  task automatic pop_rx(input int k, output logic v, output logic [7:0] d);
    @(negedge clk);
    v = rx_valid[k];
    d = rx_data[k];
    if (v) begin
      rx_ready[k] = 1'b1;
      @(negedge clk);
      rx_ready[k] = 1'b0;
    end
  endtask

  task automatic clear_status();
    @(negedge clk);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
  endtask

  // Master side of one frame: nbits bits from mosi_words, MISO captured into miso_words
  task automatic spi_xfer(input int k, input int nbits);
    logic cpol, cpha, lsb;
    cpol = (k / 2) != 0;
    cpha = (k % 2) != 0;
    lsb  = (k != 0);
    @(negedge clk);
    cs[k] = 1'b0;
    half_per();
    total++;
    if (oe[k] !== 1'b1) begin
      bad++;
      $display("FAIL oe_active[%0d]: got %b want 1", k, oe[k]);
    end
    for (int b = 0; b < nbits; b++) begin
      int w, idx;
      w   = b / 8;
      idx = lsb ? (b % 8) : (7 - b % 8);
      if (!cpha) begin
        mosi[k] = mosi_words[w][idx];
        half_per();
        miso_words[w][idx] = miso[k];
        sclk[k] = ~cpol;
        half_per();
        sclk[k] = cpol;
      end else begin
        sclk[k] = ~cpol;
        mosi[k] = mosi_words[w][idx];
        half_per();
        miso_words[w][idx] = miso[k];
        sclk[k] = cpol;
        half_per();
      end
    end
    half_per();
    cs[k] = 1'b1;
    half_per();
    half_per();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({miso[k], oe[k], tx_ready[k], rx_valid[k], frame_cnt[k], status[k]} !== {3'b001, 1'b0, 16'd0, 3'd0}) begin
        bad++;
        $display("FAIL reset[%0d]: got miso=%b oe=%b txr=%b rxv=%b fc=%0d st=%b want 0 0 1 0 0 000",
                 k, miso[k], oe[k], tx_ready[k], rx_valid[k], frame_cnt[k], status[k]);
      end
    end
  endtask

  task automatic test_fifo_exchange(input int k);
    logic v;
    logic [7:0] d, e;
    mode = 2'd0;
    push_tx(k, 8'hA5); exp_miso_q.push_back(8'hA5);
    push_tx(k, 8'h3C); exp_miso_q.push_back(8'h3C);
    mosi_words[0] = 8'h11; exp_rx_q.push_back(8'h11);
    mosi_words[1] = 8'h22; exp_rx_q.push_back(8'h22);
    spi_xfer(k, 16);
    for (int w = 0; w < 2; w++) begin
      e = exp_miso_q.pop_front();
      total++;
      if (miso_words[w] !== e) begin
        bad++;
        $display("FAIL fifo_miso[%0d][%0d]: got %h want %h", k, w, miso_words[w], e);
      end
    end
    for (int w = 0; w < 2; w++) begin
      pop_rx(k, v, d);
      e = exp_rx_q.pop_front();
      total++;
      if (!v || d !== e) begin
        bad++;
        $display("FAIL fifo_rx[%0d][%0d]: got v=%b %h want %h", k, w, v, d, e);
      end
    end
    total++;
    if (frame_cnt[k] !== 16'd1 || status[k] !== 3'b000) begin
      bad++;
      $display("FAIL fifo_fc_st[%0d]: got fc=%0d st=%b want 1 000", k, frame_cnt[k], status[k]);
    end
  endtask

  task automatic test_modes();
    for (int k = 1; k < 4; k++) test_fifo_exchange(k);
  endtask

  task automatic test_echo();
    logic v;
    logic [7:0] d, e;
    mode = 2'd1;
    mosi_words[0] = 8'h5A; mosi_words[1] = 8'hC3; mosi_words[2] = 8'h00;
    exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'h5A); exp_miso_q.push_back(8'hC3);
    exp_rx_q.push_back(8'h5A); exp_rx_q.push_back(8'hC3); exp_rx_q.push_back(8'h00);
    spi_xfer(1, 24);
    for (int w = 0; w < 3; w++) begin
      e = exp_miso_q.pop_front();
      total++;
      if (miso_words[w] !== e) begin
        bad++;
        $display("FAIL echo_miso[%0d]: got %h want %h", w, miso_words[w], e);
      end
    end
    for (int w = 0; w < 3; w++) begin
      pop_rx(1, v, d);
      e = exp_rx_q.pop_front();
      total++;
      if (!v || d !== e) begin
        bad++;
        $display("FAIL echo_rx[%0d]: got v=%b %h want %h", w, v, d, e);
      end
    end
    total++;
    if (frame_cnt[1] !== 16'd2 || status[1] !== 3'b000) begin
      bad++;
      $display("FAIL echo_fc_st: got fc=%0d st=%b want 2 000", frame_cnt[1], status[1]);
    end
  endtask

  task automatic test_underrun();
    logic v;
    logic [7:0] d, e;
    mode = 2'd0;
    mosi_words[0] = 8'h77;
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h77);
    spi_xfer(2, 8);
    e = exp_miso_q.pop_front();
    total++;
    if (miso_words[0] !== e) begin
      bad++;
      $display("FAIL underrun_miso: got %h want %h", miso_words[0], e);
    end
    total++;
    if (status[2] !== 3'b010) begin
      bad++;
      $display("FAIL underrun_status: got %b want 010", status[2]);
    end
    clear_status();
    total++;
    if (status[2] !== 3'b000) begin
      bad++;
      $display("FAIL underrun_clear: got %b want 000", status[2]);
    end
    pop_rx(2, v, d);
    e = exp_rx_q.pop_front();
    total++;
    if (!v || d !== e) begin
      bad++;
      $display("FAIL underrun_rx: got v=%b %h want %h", v, d, e);
    end
  endtask

  task automatic test_overrun();
    logic v;
    logic [7:0] d, e;
    mode = 2'd2;
    for (int w = 0; w < 3; w++) begin
      mosi_words[w] = 8'(w + 1);
      exp_miso_q.push_back(8'hFF);
    end
    exp_rx_q.push_back(8'h01);
    exp_rx_q.push_back(8'h02);
    spi_xfer(0, 24);
    for (int w = 0; w < 3; w++) begin
      e = exp_miso_q.pop_front();
      total++;
      if (miso_words[w] !== e) begin
        bad++;
        $display("FAIL overrun_miso[%0d]: got %h want %h", w, miso_words[w], e);
      end
    end
    total++;
    if (status[0] !== 3'b001) begin
      bad++;
      $display("FAIL overrun_status: got %b want 001", status[0]);
    end
    for (int w = 0; w < 2; w++) begin
      pop_rx(0, v, d);
      e = exp_rx_q.pop_front();
      total++;
      if (!v || d !== e) begin
        bad++;
        $display("FAIL overrun_rx[%0d]: got v=%b %h want %h", w, v, d, e);
      end
    end
    @(negedge clk);
    total++;
    if (rx_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL overrun_drained: got rx_valid=%b want 0", rx_valid[0]);
    end
    clear_status();
  endtask

  task automatic test_partial();
    logic [15:0] fc;
    mode = 2'd2;
    fc = frame_cnt[3];
    mosi_words[0] = 8'h1F;
    spi_xfer(3, 5);
    total++;
    if (status[3] !== 3'b100 || rx_valid[3] !== 1'b0 || frame_cnt[3] !== fc + 16'd1) begin
      bad++;
      $display("FAIL partial: got st=%b rxv=%b fc=%0d want 100 0 %0d", status[3], rx_valid[3], frame_cnt[3], fc + 16'd1);
    end
    clear_status();
  endtask

  task automatic test_reset_midframe();
    logic v;
    logic [7:0] d, e;
    mode = 2'd0;
    push_tx(0, 8'hC2);
    push_tx(0, 8'h43);
    @(negedge clk);
    cs[0] = 1'b0;
    half_per();
    sclk[0] = 1'b1;
    half_per();
    sclk[0] = 1'b0;
    half_per();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({miso[0], oe[0], tx_ready[0], rx_valid[0], frame_cnt[0], status[0]} !== {3'b001, 1'b0, 16'd0, 3'd0}) begin
      bad++;
      $display("FAIL midframe_reset: got miso=%b oe=%b txr=%b rxv=%b fc=%0d st=%b want 0 0 1 0 0 000",
               miso[0], oe[0], tx_ready[0], rx_valid[0], frame_cnt[0], status[0]);
    end
    cs[0] = 1'b1;
    mosi[0] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    push_tx(0, 8'h96); exp_miso_q.push_back(8'h96);
    mosi_words[0] = 8'h69; exp_rx_q.push_back(8'h69);
    spi_xfer(0, 8);
    e = exp_miso_q.pop_front();
    total++;
    if (miso_words[0] !== e) begin
      bad++;
      $display("FAIL midframe_miso: got %h want %h", miso_words[0], e);
    end
    pop_rx(0, v, d);
    e = exp_rx_q.pop_front();
    total++;
    if (!v || d !== e) begin
      bad++;
      $display("FAIL midframe_rx: got v=%b %h want %h", v, d, e);
    end
    total++;
    if (frame_cnt[0] !== 16'd1 || status[0] !== 3'b000) begin
      bad++;
      $display("FAIL midframe_fc_st: got fc=%0d st=%b want 1 000", frame_cnt[0], status[0]);
    end
  endtask

  initial begin
    rstn = 1'b0;
    status_clr = 1'b0;
    mode = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cs[k] = 1'b1;
      sclk[k] = (k / 2) != 0;
      mosi[k] = 1'b0;
      tx_valid[k] = 1'b0;
      tx_data[k] = 8'h00;
      rx_ready[k] = 1'b0;
    end
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_fifo_exchange(0);
    test_modes();
    test_echo();
    test_underrun();
    test_overrun();
    test_partial();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_model.md
Name: spi_slave_model

Overview:
- Parametrised, synthesizable SPI slave responder for chip-level simulation and FPGA self-test.
- Replaces the fixed MOSI-to-MISO SPI loopback tie-off at top level.
- Oversamples SCLK/CS/MOSI on the system clock and supports all four CPOL/CPHA modes, configurable word width and LSB/MSB order.
- Holds RX and TX FIFOs and three response modes (FIFO, echo, fill), so the bench or an on-chip checker can script and inspect traffic.

Parameters:
- DATA_W, 8, bits per SPI word (4..32).
- RX_DEPTH, 16, RX FIFO depth in words (power of 2, ≥2).
- TX_DEPTH, 16, TX FIFO depth in words (power of 2, ≥2).
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
- LSB_FIRST, 0, 1 = bit 0 shifted first.
- FILL, all-ones, word sent on underrun and in fill mode.

Ports:
- clk  in  1  system clock, ≥8× SCLK frequency.
- rstn  in  1  synchronous, active-low reset.
- spi_cs  in  1  chip select, active low, asynchronous to clk.
- spi_sclk  in  1  SPI clock, asynchronous.
- spi_mosi  in  1  master data out, asynchronous.
- spi_miso  out  1  slave data out.
- spi_miso_oe  out  1  MISO output enable (top level tristates MISO when 0).
- mode  in  2  0 = FIFO, 1 = echo, 2 = fill, 3 = reserved (behaves as fill); sampled at CS fall.
- tx_valid  in  1  TX FIFO push request.
- tx_ready  out  1  TX FIFO not full.
- tx_data  in  DATA_W  TX word.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  RX FIFO pop.
- rx_data  out  DATA_W  RX FIFO head (first-word fall-through).
- frame_cnt  out  16  completed CS-low frames, wraps at 16 bits.
- status  out  3  sticky flags: [0] rx_overrun, [1] tx_underrun, [2] partial_word.
- status_clr  in  1  clears all status bits.

Behaviour:
- Reset (rstn=0 at a clk edge): FIFOs empty; frame_cnt=0; status=0; state IDLE; spi_miso=0; spi_miso_oe=0; tx_ready=1; rx_valid=0.
- Input sync: spi_cs, spi_sclk and spi_mosi each pass through a 2-flop synchroniser. A third SCLK flop gives edge detect.
  - Leading edge = rise when CPOL=0, fall when CPOL=1.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- spi_miso_oe = registered inverse of synchronised CS. Latency from a CS pin change is 3 clk.
- States:
  - IDLE → LOAD on synchronised CS fall. The mode input is latched here.
  - LOAD lasts one cycle. It selects the outgoing word:
    - FIFO mode: TX head, popped; if the TX FIFO is empty, send FILL and set status[1].
    - Echo mode: last complete RX word of the current frame; FILL for the first word of a frame.
    - Fill mode: FILL.
    - Then go to SHIFT with bit_cnt=0.
  - SHIFT:
    - Sample edge: capture MOSI into the RX shift register and increment bit_cnt.
    - When bit_cnt reaches DATA_W: push the word to the RX FIFO (if full, drop the word and set status[0]), reset bit_cnt to 0, and reload the TX word in the same cycle by the LOAD rules (no extra cycle).
  - Any state → IDLE on synchronised CS rise:
    - frame_cnt increments.
    - If bit_cnt≠0, discard the partial word and set status[2].
- MISO timing:
  - CPHA=0: spi_miso takes the first bit at load. Each shift edge presents the next bit.
  - CPHA=1: spi_miso is unchanged at load. Each shift edge presents the current bit, then advances the bit pointer.
  - Bit order follows LSB_FIRST.
  - In IDLE, spi_miso holds its last value (oe=0).
- FIFOs: push and pop in the same cycle are legal on full and on empty. Bench pushes when full and pops when empty are ignored.
- Status: status_clr together with a new set event in the same cycle → the bit ends set.
- SCLK edges while CS is high are ignored.

Decomposition:
- Package spi_slave_pkg: mode enum (MODE_FIFO, MODE_ECHO, MODE_FILL) and status bit index constants.
- Sub-module spi_slave_fifo: parametrised width/depth synchronous FIFO with first-word fall-through; instantiated twice (RX and TX).
- The synchroniser is inline.

Test Plan:
- Mode 0, FIFO mode: push TX 0xA5, 0x3C; master sends 0x11, 0x22 in one frame → MISO bytes 0xA5, 0x3C; RX pops 0x11, 0x22; frame_cnt=1; status=0.
- Repeat the exchange for CPOL/CPHA = 01, 10, 11 with LSB_FIRST=1 → same byte values recovered on both sides.
- Echo mode: master sends 0x5A, 0xC3, 0x00 → MISO 0xFF, 0x5A, 0xC3.
- Underrun: TX FIFO empty, FIFO mode, send 1 byte → MISO 0xFF; status=3'b010. Assert status_clr → status=0.
- Overrun with RX_DEPTH=2: send 3 bytes without popping → RX FIFO holds the first two; status[0]=1.
- CS raised after 5 bits → no RX push; status[2]=1; frame_cnt increments. A rstn pulse mid-frame → all outputs return to reset values and the next frame decodes correctly.
